// File: rtl/rv_pkg.sv
// Shared RV32I core types: register address and the ID->EX pipeline register bundle.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    reg_addr_t       rd;
    logic            rd_we;
    logic            is_load;
  } ex_bundle_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: x0, then EX bypass (OPF_EX_BYPASS_EN only), then WB bypass, then RF.
module operand_bypass_mux
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  reg_addr_t             s,
  input  logic [DATA_WIDTH-1:0] rf_data,
`ifdef OPF_EX_BYPASS_EN
  input  logic                  ex_fwd_en,
  input  reg_addr_t             ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
`endif
  input  logic                  wb_en,
  input  reg_addr_t             wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (s == '0) begin
      operand = '0;
    end
`ifdef OPF_EX_BYPASS_EN
    else if (ex_fwd_en && (ex_rd == s)) begin
      operand = ex_data;
    end
`endif
    else if (wb_en && (wb_addr == s)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID->EX stage: operand resolution, load-use hazard detection and the EX pipeline register.
// Optional EX-result bypass enabled by defining OPF_EX_BYPASS_EN.
module operand_fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,  // must match XLEN: the EX bundle is XLEN wide
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [31:0]           id_pc,
  input  reg_addr_t             id_rs1,
  input  reg_addr_t             id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  reg_addr_t             id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic [DATA_WIDTH-1:0] id_imm,
  output reg_addr_t             rf_addr_a,
  output reg_addr_t             rf_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_data_a,
  input  logic [DATA_WIDTH-1:0] rf_data_b,
  input  logic                  wb_en,
  input  reg_addr_t             wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_op_a,
  output logic [DATA_WIDTH-1:0] ex_op_b,
  output reg_addr_t             ex_rd,
  output logic                  ex_rd_we,
  output logic                  ex_is_load,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  ex_bundle_t           ex_q, ex_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic                 rd_match, hazard;

  assign rf_addr_a = id_rs1;
  assign rf_addr_b = id_rs2;

`ifdef OPF_EX_BYPASS_EN
  logic ex_fwd_en;
  assign ex_fwd_en = ex_valid_q && ex_q.rd_we && !ex_q.is_load;
`else
  logic unused_ex_alu_result;
  assign unused_ex_alu_result = ^ex_alu_result;
`endif

  operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_a (
    .s         (id_rs1),
    .rf_data   (rf_data_a),
`ifdef OPF_EX_BYPASS_EN
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_q.rd),
    .ex_data   (ex_alu_result),
`endif
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .operand   (op_a)
  );

  operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_b (
    .s         (id_rs2),
    .rf_data   (rf_data_b),
`ifdef OPF_EX_BYPASS_EN
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_q.rd),
    .ex_data   (ex_alu_result),
`endif
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .operand   (op_b)
  );

  // Without the EX bypass every EX-stage RAW must wait one cycle for the WB bypass.
  always_comb begin
    rd_match = (id_use_rs1 && (ex_q.rd == id_rs1)) ||
               (id_use_rs2 && (ex_q.rd == id_rs2));
    hazard   = id_valid && ex_valid_q && ex_q.rd_we && (ex_q.rd != '0) && rd_match;
`ifdef OPF_EX_BYPASS_EN
    hazard   = hazard && ex_q.is_load;
`endif
  end

  assign id_ready = ex_ready && !hazard;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (!ex_ready) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard || !id_valid) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d    = 1'b1;
      ex_d.pc       = id_pc;
      ex_d.imm      = id_imm;
      ex_d.op_a     = op_a;
      ex_d.op_b     = op_b;
      ex_d.rd       = id_rd;
      ex_d.rd_we    = id_rd_we;
      ex_d.is_load  = id_is_load;
    end

    stall_d = stall_q;
    if (hazard && ex_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_q.pc;
  assign ex_imm     = ex_q.imm;
  assign ex_op_a    = ex_q.op_a;
  assign ex_op_b    = ex_q.op_b;
  assign ex_rd      = ex_q.rd;
  assign ex_rd_we   = ex_q.rd_we;
  assign ex_is_load = ex_q.is_load;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, random traffic against a reference model,
// and a stall-counter saturation sequence. Honours OPF_EX_BYPASS_EN.
module tb_operand_fetch_stage;

  localparam int unsigned CW     = 4;
  localparam int unsigned CNTMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_rs1, id_use_rs2, id_rd_we, id_is_load;
  logic [31:0] id_pc, id_imm, rf_data_a, rf_data_b, wb_data, ex_alu_result;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_addr;
  logic        wb_en, flush, ex_ready;
  logic        id_ready, ex_valid, ex_rd_we, ex_is_load;
  logic [4:0]  rf_addr_a, rf_addr_b, ex_rd;
  logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [CW-1:0] stall_cnt;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_imm(id_imm),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_alu_result(ex_alu_result),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid, m_we, m_ld, m_rst;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_imm, m_a, m_b;
  int unsigned m_cnt;

  function automatic bit m_hazard();
    bit h;
    h = id_valid && m_valid && m_we && (m_rd != 0) &&
        ((id_use_rs1 && m_rd == id_rs1) || (id_use_rs2 && m_rd == id_rs2));
`ifdef OPF_EX_BYPASS_EN
    h = h && m_ld;
`endif
    return h;
  endfunction

  function automatic logic [31:0] m_resolve(input logic [4:0] s, input logic [31:0] rf);
    if (s == 0) return 32'd0;
`ifdef OPF_EX_BYPASS_EN
    if (m_valid && m_we && !m_ld && m_rd == s) return ex_alu_result;
`endif
    if (wb_en && wb_addr == s) return wb_data;
    return rf;
  endfunction

  task automatic m_update();
    bit h;
    logic [31:0] a, b;
    if (rst) begin
      m_rst = 1; m_valid = 0; m_we = 0; m_ld = 0; m_rd = 0;
      m_pc = 0; m_imm = 0; m_a = 0; m_b = 0; m_cnt = 0;
    end else begin
      m_rst = 0;
      h = m_hazard();
      a = m_resolve(id_rs1, rf_data_a);
      b = m_resolve(id_rs2, rf_data_b);
      if (h && ex_ready && !flush && m_cnt < CNTMAX) m_cnt++;
      if (flush) m_valid = 0;
      else if (!ex_ready) m_valid = m_valid;
      else if (h || !id_valid) m_valid = 0;
      else begin
        m_valid = 1; m_pc = id_pc; m_imm = id_imm; m_a = a; m_b = b;
        m_rd = id_rd; m_we = id_rd_we; m_ld = id_is_load;
      end
    end
  endtask

  task automatic model_cycle();
    #1;
    chk("id_ready", {31'd0, id_ready}, {31'd0, ex_ready && !m_hazard()});
    chk("rf_addr_a", {27'd0, rf_addr_a}, {27'd0, id_rs1});
    chk("rf_addr_b", {27'd0, rf_addr_b}, {27'd0, id_rs2});
    @(posedge clk);
    #1;
    m_update();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
    if (m_valid || m_rst) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_op_a", ex_op_a, m_a);
      chk("ex_op_b", ex_op_b, m_b);
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      chk("ex_rd_we", {31'd0, ex_rd_we}, {31'd0, m_we});
      chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, m_ld});
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, vld, u1, u2, we, ld, wen, fl, exr;
    logic [31:0] pc, imm, rfa, rfb, wdata, alu;
    logic [4:0]  rs1, rs2, rd, waddr;
    bit chk_rdy, e_rdy, e_vld, chk_ops;
    logic [31:0] e_a, e_b;
    logic [CW-1:0] e_cnt;
  } vec_t;

  function automatic vec_t blank();
    vec_t r;
    r.rst = 0; r.vld = 0; r.u1 = 0; r.u2 = 0; r.we = 0; r.ld = 0; r.wen = 0; r.fl = 0;
    r.exr = 1; r.pc = 0; r.imm = 0; r.rfa = 0; r.rfb = 0; r.wdata = 0; r.alu = 0;
    r.rs1 = 0; r.rs2 = 0; r.rd = 0; r.waddr = 0;
    r.chk_rdy = 1; r.e_rdy = 1; r.e_vld = 0; r.chk_ops = 1; r.e_a = 0; r.e_b = 0; r.e_cnt = 0;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    rst = r.rst; id_valid = r.vld; id_pc = r.pc; id_rs1 = r.rs1; id_rs2 = r.rs2;
    id_use_rs1 = r.u1; id_use_rs2 = r.u2; id_rd = r.rd; id_rd_we = r.we; id_is_load = r.ld;
    id_imm = r.imm; rf_data_a = r.rfa; rf_data_b = r.rfb; wb_en = r.wen; wb_addr = r.waddr;
    wb_data = r.wdata; ex_alu_result = r.alu; flush = r.fl; ex_ready = r.exr;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t r;
    // reset, two cycles
    r = blank(); r.rst = 1; r.chk_rdy = 0; tbl.push_back(r);
    r = blank(); r.rst = 1; tbl.push_back(r);
    // WB bypass beats RF for x5
    r = blank(); r.vld = 1; r.pc = 32'h100; r.imm = 32'h5; r.rs1 = 5; r.u1 = 1; r.rfa = 32'h11;
    r.wen = 1; r.waddr = 5; r.wdata = 32'hDEAD; r.rd = 1; r.we = 1;
    r.e_vld = 1; r.e_a = 32'hDEAD; tbl.push_back(r);
    // x0 ignores WB bypass; issue load rd=7
    r = blank(); r.vld = 1; r.pc = 32'h104; r.rs1 = 0; r.u1 = 1; r.rfa = 32'h1234;
    r.rs2 = 2; r.u2 = 1; r.rfb = 32'h22; r.wen = 1; r.waddr = 0; r.wdata = 32'hFFFF;
    r.rd = 7; r.we = 1; r.ld = 1; r.e_vld = 1; r.e_a = 0; r.e_b = 32'h22; tbl.push_back(r);
    // load-use on rs2=7: stall one cycle
    r = blank(); r.vld = 1; r.pc = 32'h108; r.rs1 = 9; r.u1 = 1; r.rfa = 32'h99;
    r.rs2 = 7; r.u2 = 1; r.rfb = 32'hBAD; r.rd = 3; r.we = 1; r.alu = 32'h1111;
    r.e_rdy = 0; r.e_vld = 0; r.chk_ops = 0; r.e_cnt = 1; tbl.push_back(r);
    // held instruction, load data now arrives on WB
    r.wen = 1; r.waddr = 7; r.wdata = 32'h55; r.e_rdy = 1; r.e_vld = 1; r.chk_ops = 1;
    r.e_a = 32'h99; r.e_b = 32'h55; tbl.push_back(r);
    // ALU RAW on x3
    r = blank(); r.vld = 1; r.pc = 32'h10C; r.rs1 = 3; r.u1 = 1; r.rfa = 0; r.rd = 4; r.we = 1;
    r.alu = 32'h40;
`ifdef OPF_EX_BYPASS_EN
    r.e_vld = 1; r.e_a = 32'h40; r.e_cnt = 1;
`else
    r.e_rdy = 0; r.e_vld = 0; r.chk_ops = 0; r.e_cnt = 2;
`endif
    tbl.push_back(r);
    r.wen = 1; r.waddr = 3; r.wdata = 32'h40; r.alu = 32'h77;
    r.e_rdy = 1; r.e_vld = 1; r.chk_ops = 1; r.e_a = 32'h40; r.e_b = 0;
    tbl.push_back(r);
    // ex_ready low: hold everything
    r = blank(); r.vld = 1; r.pc = 32'h110; r.rs1 = 1; r.u1 = 1; r.rfa = 32'hAAAA; r.rd = 5;
    r.exr = 0; r.e_rdy = 0; r.e_vld = 1; r.e_a = 32'h40; r.e_b = 0;
`ifdef OPF_EX_BYPASS_EN
    r.e_cnt = 1;
`else
    r.e_cnt = 2;
`endif
    tbl.push_back(r);
    // flush while stalled still kills EX
    r.fl = 1; r.e_vld = 0; r.chk_ops = 0; tbl.push_back(r);
    // reset overrides flush and a valid ID
    r.rst = 1; r.exr = 1; r.e_rdy = 1; r.chk_ops = 1; r.e_a = 0; r.e_b = 0; r.e_cnt = 0;
    tbl.push_back(r);
    // load rd=6, then unused sources naming x6 must not stall
    r = blank(); r.vld = 1; r.rd = 6; r.we = 1; r.ld = 1; r.e_vld = 1; tbl.push_back(r);
    r = blank(); r.vld = 1; r.rs1 = 6; r.rs2 = 6; r.rfa = 32'h66; r.rfb = 32'h67;
    r.e_vld = 1; r.e_a = 32'h66; r.e_b = 32'h67; tbl.push_back(r);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].chk_rdy) chk($sformatf("v%0d_id_ready", i), {31'd0, id_ready}, {31'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      m_update();
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("v%0d_stall_cnt", i), {28'd0, stall_cnt}, {28'd0, tbl[i].e_cnt});
      if (tbl[i].chk_ops) begin
        chk($sformatf("v%0d_ex_op_a", i), ex_op_a, tbl[i].e_a);
        chk($sformatf("v%0d_ex_op_b", i), ex_op_b, tbl[i].e_b);
      end
      @(negedge clk);
    end

    // random traffic against the model
    rst = 1; model_cycle();
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      id_valid      = ($urandom_range(0, 4) != 0);
      id_pc         = $urandom;
      id_imm        = $urandom;
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_use_rs1    = $urandom_range(0, 1) == 1;
      id_use_rs2    = $urandom_range(0, 1) == 1;
      id_rd         = 5'($urandom_range(0, 7));
      id_rd_we      = ($urandom_range(0, 3) != 0);
      id_is_load    = ($urandom_range(0, 2) == 0);
      rf_data_a     = $urandom;
      rf_data_b     = $urandom;
      wb_en         = $urandom_range(0, 1) == 1;
      wb_addr       = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      ex_alu_result = $urandom;
      flush         = ($urandom_range(0, 9) == 0);
      ex_ready      = ($urandom_range(0, 4) != 0);
      model_cycle();
    end

    // repeated load-use stalls drive the counter into saturation
    r = blank(); r.rst = 1; drive(r); model_cycle();
    for (int k = 0; k < 20; k++) begin
      r = blank(); r.vld = 1; r.rd = 7; r.we = 1; r.ld = 1; drive(r); model_cycle();
      r = blank(); r.vld = 1; r.rd = 2; r.we = 1; r.rs2 = 7; r.u2 = 1; drive(r); model_cycle();
    end
    chk("stall_sat", {28'd0, stall_cnt}, CNTMAX);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
